// File: rtl/pong_ball_ctrl_if.sv
// Ball controller bus: game-step strobe, paddle and serve inputs in,
// ball position and game status out.
interface pong_ball_ctrl_if;
    logic       tick;
    logic [9:0] paddle_x;
    logic       serve_n;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       ball_visible;
    logic [7:0] score;
    logic [2:0] lives;
    logic       game_over;
    logic [1:0] state;

    modport master (
        output tick, paddle_x, serve_n,
        input  ball_x, ball_y, ball_visible, score, lives, game_over, state
    );

    modport slave (
        input  tick, paddle_x, serve_n,
        output ball_x, ball_y, ball_visible, score, lives, game_over, state
    );
endinterface

// File: rtl/pong_ball_ctrl.sv
// Pong ball sequencer: serve, motion, wall/paddle bounces, misses,
// score and lives. Advances on the one-cycle tick strobe; all outputs
// come straight from registers.
module pong_ball_ctrl #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int BALL_SIZE  = 8,
    parameter int PADDLE_W   = 48,
    parameter int PADDLE_Y   = 448,
    parameter int STEP       = 2,
    parameter int LIVES      = 3,
    parameter int MISS_DELAY = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    pong_ball_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_SERVE = 2'd0,
        S_PLAY  = 2'd1,
        S_MISS  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    // All geometry compares run in 11 bits so x+STEP etc. never wrap.
    localparam logic [10:0] X_MAX     = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] Y_MAX     = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [10:0] BS_W      = 11'(BALL_SIZE);
    localparam logic [10:0] PW_W      = 11'(PADDLE_W);
    localparam logic [10:0] PY_W      = 11'(PADDLE_Y);
    localparam logic [10:0] SERVE_OFS = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [8:0]  REST_Y    = 9'(PADDLE_Y - BALL_SIZE);
    localparam logic [7:0]  MISS_INIT = 8'(MISS_DELAY);
    localparam logic [2:0]  LIVES_W   = 3'(LIVES);

    state_t     state_q, state_nxt;
    logic [9:0] bx_q, bx_nxt;
    logic [8:0] by_q, by_nxt;
    logic       vis_q, vis_nxt;
    logic [7:0] score_q, score_nxt;
    logic [2:0] lives_q, lives_nxt;
    logic       go_q, go_nxt;
    logic       dx_q, dx_nxt;      // 1 = moving right
    logic       dy_q, dy_nxt;      // 1 = moving down
    logic       sdir_q, sdir_nxt;  // direction of the next serve, 1 = right
    logic [7:0] mcnt_q, mcnt_nxt;
    logic       serve_q;

    logic [10:0] x11, y11, px11;
    logic        press;
    logic        hit;

    // State and datapath registers; reset puts the ball resting on the paddle row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_SERVE;
            bx_q    <= '0;
            by_q    <= REST_Y;
            vis_q   <= 1'b1;
            score_q <= '0;
            lives_q <= LIVES_W;
            go_q    <= 1'b0;
            dx_q    <= 1'b1;
            dy_q    <= 1'b0;
            sdir_q  <= 1'b1;
            mcnt_q  <= '0;
            serve_q <= 1'b1;
        end else begin
            state_q <= state_nxt;
            bx_q    <= bx_nxt;
            by_q    <= by_nxt;
            vis_q   <= vis_nxt;
            score_q <= score_nxt;
            lives_q <= lives_nxt;
            go_q    <= go_nxt;
            dx_q    <= dx_nxt;
            dy_q    <= dy_nxt;
            sdir_q  <= sdir_nxt;
            mcnt_q  <= mcnt_nxt;
            serve_q <= bus.serve_n;
        end
    end

    // Next-state and datapath: one game step per tick in PLAY, axes handled independently.
    always_comb begin
        state_nxt = state_q;
        bx_nxt    = bx_q;
        by_nxt    = by_q;
        vis_nxt   = vis_q;
        score_nxt = score_q;
        lives_nxt = lives_q;
        go_nxt    = go_q;
        dx_nxt    = dx_q;
        dy_nxt    = dy_q;
        sdir_nxt  = sdir_q;
        mcnt_nxt  = mcnt_q;

        x11   = {1'b0, bx_q};
        y11   = {2'b00, by_q};
        px11  = {1'b0, bus.paddle_x};
        // Falling edge of the button against its registered copy.
        press = serve_q & ~bus.serve_n;
        // Ball bottom is at or just above the paddle row and reaches it this step,
        // with horizontal overlap on the current (pre-move) position.
        hit   = dy_q
              && (y11 + BS_W <= PY_W)
              && (y11 + BS_W + STEP_W >= PY_W)
              && (x11 + BS_W > px11)
              && (x11 < px11 + PW_W);

        unique case (state_q)
            S_SERVE: begin
                bx_nxt = 10'(px11 + SERVE_OFS);
                by_nxt = REST_Y;
                if (press) begin
                    dx_nxt    = sdir_q;
                    dy_nxt    = 1'b0;
                    sdir_nxt  = ~sdir_q;
                    state_nxt = S_PLAY;
                end
            end

            S_PLAY: begin
                if (bus.tick) begin
                    if (!dx_q && (x11 < STEP_W)) begin
                        bx_nxt = '0;
                        dx_nxt = 1'b1;
                    end else if (dx_q && (x11 + STEP_W > X_MAX)) begin
                        bx_nxt = 10'(X_MAX);
                        dx_nxt = 1'b0;
                    end else if (dx_q) begin
                        bx_nxt = 10'(x11 + STEP_W);
                    end else begin
                        bx_nxt = 10'(x11 - STEP_W);
                    end

                    if (!dy_q) begin
                        if (y11 < STEP_W) begin
                            by_nxt = '0;
                            dy_nxt = 1'b1;
                        end else begin
                            by_nxt = 9'(y11 - STEP_W);
                        end
                    end else if (hit) begin
                        by_nxt = REST_Y;
                        dy_nxt = 1'b0;
                        if (score_q != 8'hFF) score_nxt = score_q + 8'd1;
                    end else if (y11 + STEP_W > Y_MAX) begin
                        // Ball lost: y holds, ball hidden until the next serve.
                        lives_nxt = lives_q - 3'd1;
                        vis_nxt   = 1'b0;
                        mcnt_nxt  = MISS_INIT;
                        if (lives_q == 3'd1) begin
                            state_nxt = S_OVER;
                            go_nxt    = 1'b1;
                        end else begin
                            state_nxt = S_MISS;
                        end
                    end else begin
                        by_nxt = 9'(y11 + STEP_W);
                    end
                end
            end

            S_MISS: begin
                if (bus.tick) begin
                    mcnt_nxt = mcnt_q - 8'd1;
                    if (mcnt_q == 8'd1) begin
                        vis_nxt   = 1'b1;
                        state_nxt = S_SERVE;
                    end
                end
            end

            S_OVER: begin
                // Restart only re-arms the game; launching takes another press.
                if (press) begin
                    score_nxt = '0;
                    lives_nxt = LIVES_W;
                    go_nxt    = 1'b0;
                    vis_nxt   = 1'b1;
                    state_nxt = S_SERVE;
                end
            end
        endcase
    end

    assign bus.ball_x       = bx_q;
    assign bus.ball_y       = by_q;
    assign bus.ball_visible = vis_q;
    assign bus.score        = score_q;
    assign bus.lives        = lives_q;
    assign bus.game_over    = go_q;
    assign bus.state        = state_q;

endmodule

// File: doc/pong_ball_ctrl.md
# pong_ball_ctrl

Game sequencer for the Pong VGA design. Owns the ball: serve, motion, wall and paddle bounces, miss detection, score and lives, game-over. Runs in the fast `clk` domain and advances on a one-cycle `tick` strobe from the game clock divider. Outputs feed the pixel compare logic beside the paddle renderer.

## Interface
- `SCREEN_W`, 640, visible width in pixels
- `SCREEN_H`, 480, visible height in pixels
- `BALL_SIZE`, 8, ball edge length in pixels
- `PADDLE_W`, 48, paddle width in pixels
- `PADDLE_Y`, 448, paddle top row
- `STEP`, 2, ball pixels per tick per axis
- `LIVES`, 3, lives per game (1..7)
- `MISS_DELAY`, 64, ticks the ball stays hidden after a miss (1..255)

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `tick`  in  1  one-`clk` game-step strobe
- `paddle_x`  in  10  paddle left edge, 0..SCREEN_W-PADDLE_W
- `serve_n`  in  1  serve button, active-low, debounced, `clk`-synchronous
- `ball_x`  out  10  ball left edge
- `ball_y`  out  9  ball top edge
- `ball_visible`  out  1  ball drawn when 1
- `score`  out  8  paddle hits, saturates at 255
- `lives`  out  3  remaining lives
- `game_over`  out  1  high in OVER
- `state`  out  2  SERVE=0, PLAY=1, MISS=2, OVER=3

## Operation
- Reset values: state SERVE, ball_x 0, ball_y PADDLE_Y-BALL_SIZE (440), ball_visible 1, score 0, lives LIVES, game_over 0, dx +, dy −, serve direction +, miss counter 0.
- Serve press is the falling edge of `serve_n`, detected against a registered copy. A held button never retriggers.
- SERVE: every `clk`, ball_x <= paddle_x + PADDLE_W/2 − BALL_SIZE/2 (paddle_x+20), ball_y <= 440. On a press: dx <= serve direction, dy <= up, serve direction toggles, state moves to PLAY. The first serve goes right.
- PLAY: on each `tick`, the x and y axes update independently in the same tick, so corners flip both:
  - Left wall: moving left and ball_x < STEP -> ball_x <= 0, dx <= +.
  - Right wall: moving right and ball_x + STEP > SCREEN_W−BALL_SIZE -> ball_x <= 632, dx <= −.
  - Top wall: moving up and ball_y < STEP -> ball_y <= 0, dy <= down.
  - Paddle hit: moving down, ball_y+BALL_SIZE <= PADDLE_Y, ball_y+BALL_SIZE+STEP >= PADDLE_Y, ball_x+BALL_SIZE > paddle_x, and ball_x < paddle_x+PADDLE_W -> ball_y <= 440, dy <= up, score +1 (saturating).
  - Miss: moving down, no paddle hit, and ball_y+STEP > SCREEN_H−BALL_SIZE -> lives −1, ball_visible <= 0, miss counter <= MISS_DELAY. State goes to OVER if lives was 1, otherwise to MISS.
  - Otherwise: ball_x ± STEP, ball_y ± STEP.
- Arithmetic: compares use 11-bit unsigned, so there is no wrap. Positions never leave 0..632 (x) and 0..472 (y).
- MISS: each tick decrements the miss counter. When it reaches 0: ball_visible <= 1, state moves to SERVE. Presses are ignored.
- OVER: game_over=1, ball_visible=0. A press sets score <= 0, lives <= LIVES, game_over <= 0, ball_visible <= 1, state moves to SERVE. The press does not also launch.
- `tick` outside PLAY and MISS has no effect. In PLAY, a press has no effect.

## Timing
- All outputs are registered and change only on a `clk` rising edge, or asynchronously on reset.
- Motion latency: 1 `clk` after the edge where `tick`=1.
- Serve latency: state=PLAY on the edge after the press edge is sampled. First motion occurs at the next `tick`.
- SERVE tracking: ball_x follows paddle_x with 1 `clk` latency.
- Miss to SERVE: exactly MISS_DELAY ticks.
- `rst_n` low mid-game: immediate return to all reset values. Operation resumes on the first `clk` edge after deassertion.

## Test plan
- Reset, paddle_x=100, serve press -> ball_x=120, ball_y=440 in SERVE. After the press, state=1. After 1 tick: ball_x=122, ball_y=438.
- Ball at x=631, y=200, dx+, dy− in PLAY; tick -> ball_x=632, dx−, ball_y=198. Ball at x=0, y=1, dx−, dy−; tick -> x=0, y=0, both velocities flip.
- Ball at x=200, y=439 moving down, paddle_x=180; tick -> ball_y=440, dy up, score=1. Score at 255 stays 255 after a further hit.
- Ball at x=400, y=471 moving down, paddle_x=0; tick -> lives 3->2, ball_visible=0, state=2. After MISS_DELAY ticks, state=0 and ball_visible=1. A press during MISS is ignored.
- Three misses -> lives=0, state=3, game_over=1. Press -> score=0, lives=3, state=0, no launch until a second press.
- Assert `rst_n` mid-PLAY between clock edges -> outputs take reset values immediately, with no `clk` edge required.
